// File: rtl/cla16_mp_sequencer.sv
// Multi-precision add/subtract sequencer driving one external 16-bit adder.
// It processes one limb per clock, least-significant limb first, chaining carry between limbs.
module cla16_mp_sequencer #(
  parameter int WORDS = 4,
  parameter int IDXW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sub,
  input  logic [16*WORDS-1:0] in_a,
  input  logic [16*WORDS-1:0] in_b,
  output logic [15:0]         add_a,
  output logic [15:0]         add_b,
  output logic                add_cin,
  input  logic [15:0]         add_sum,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] out_result,
  output logic                out_cout,
  output logic                out_ovf,
  output logic                out_zero
);

  localparam int W = 16 * WORDS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [W-1:0]    a_reg, b_reg, work_reg, work_next, result_reg;
  logic            cout_reg, ovf_reg, zero_reg;
  logic            accept, last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == IDXW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        add_a   = a_reg[{idx, 4'b0000} +: 16];
        add_b   = b_reg[{idx, 4'b0000} +: 16];
        add_cin = carry;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Working result with the current limb already merged, so the zero flag sees the final limb.
  always_comb begin
    work_next                           = work_reg;
    work_next[{idx, 4'b0000} +: 16]     = add_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      work_reg   <= '0;
      result_reg <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_sub ? ~in_b : in_b;
      carry <= in_sub;
      idx   <= '0;
    end else if (state == RUN) begin
      work_reg <= work_next;
      carry    <= add_cout;
      idx      <= idx + IDXW'(1);
      if (last) begin
        result_reg <= work_next;
        cout_reg   <= add_cout;
        ovf_reg    <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[15] != a_reg[W-1]);
        zero_reg   <= (work_next == '0);
      end
    end
  end

  assign out_result = result_reg;
  assign out_cout   = cout_reg;
  assign out_ovf    = ovf_reg;
  assign out_zero   = zero_reg;

endmodule

// File: tb/tb_cla16_mp_sequencer.sv
// Directed self-checking bench for cla16_mp_sequencer with WORDS = 4.
// The bench models the external combinational 16-bit adder.
module tb_cla16_mp_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub;
  logic [63:0] in_a, in_b;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        out_cout, out_ovf, out_zero;

  int vectors    = 0;
  int miscompares = 0;

  cla16_mp_sequencer #(.WORDS(4), .IDXW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout),
    .out_ovf(out_ovf), .out_zero(out_zero)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one operation end to end, checking latency, carry-in sequence, result and flags.
  task automatic apply_stimulus(input string tag, input logic sub, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] exp_result, input logic exp_cout, input logic exp_ovf,
                                input logic exp_zero, input logic [3:0] exp_cin, input logic [15:0] exp_b0);
    logic [3:0]  cin_seq;
    logic [3:0]  valid_seq;
    logic [15:0] b0;
    cin_seq   = '0;
    valid_seq = '0;
    b0        = '0;
    @(negedge clk);
    in_valid = 1'b1; in_sub = sub; in_a = a; in_b = b;
    check_output({tag, "_in_ready"}, {63'h0, in_ready}, 64'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_a = 64'hDEAD_BEEF_DEAD_BEEF; in_b = 64'h0123_4567_89AB_CDEF; in_sub = ~sub;
    for (int k = 0; k < 4; k++) begin
      cin_seq[k]   = add_cin;
      valid_seq[k] = out_valid;
      if (k == 0) b0 = add_b;
      @(posedge clk);
      #1;
    end
    check_output({tag, "_valid_early"}, {60'h0, valid_seq}, 64'h0);
    check_output({tag, "_cin_seq"}, {60'h0, cin_seq}, {60'h0, exp_cin});
    check_output({tag, "_add_b0"}, {48'h0, b0}, {48'h0, exp_b0});
    check_output({tag, "_out_valid"}, {63'h0, out_valid}, 64'h1);
    check_output({tag, "_result"}, out_result, exp_result);
    check_output({tag, "_flags"}, {61'h0, out_cout, out_ovf, out_zero}, {61'h0, exp_cout, exp_ovf, exp_zero});
    check_output({tag, "_adder_idle"}, {31'h0, add_a, add_b, add_cin}, 64'h0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_output({tag, "_released"}, {62'h0, out_valid, in_ready}, 64'h1);
  endtask

  initial begin
    logic [63:0] held_result;
    logic [3:0]  late_valid;
    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_outputs", {out_result[15:0], 13'h0, out_cout, out_ovf, out_zero, 15'h0, out_valid, 15'h0, in_ready},
                 64'h0000_0000_0000_0001);
    check_output("reset_adder", {31'h0, add_a, add_b, add_cin}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus("add_carry16", 1'b0, 64'h0000_0000_0000_FFFF, 64'h1,
                   64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 4'b0010, 16'h0001);
    apply_stimulus("add_wrap0", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                   64'h0, 1'b1, 1'b0, 1'b1, 4'b1110, 16'h0001);
    apply_stimulus("sub_5m7", 1'b1, 64'h5, 64'h7,
                   64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'b0001, 16'hFFF8);
    apply_stimulus("add_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 4'b1110, 16'h0001);
    apply_stimulus("sub_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'h1,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 4'b0001, 16'hFFFE);

    // Backpressure: result held while out_ready is low, competing request refused.
    @(negedge clk);
    in_valid = 1'b1; in_sub = 1'b0; in_a = 64'h0000_0000_0000_1234; in_b = 64'h0000_0000_0000_1111;
    @(posedge clk);
    #1;
    in_sub = 1'b1; in_a = 64'h10; in_b = 64'h3;
    repeat (4) @(posedge clk);
    #1;
    held_result = out_result;
    check_output("hold_first_result", held_result, 64'h0000_0000_0000_2345);
    for (int c = 0; c < 10; c++) begin
      check_output("hold_state", {out_result[31:0], 27'h0, out_valid, in_ready, out_cout, out_ovf, out_zero},
                   {held_result[31:0], 27'h0, 5'b10000});
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_output("hold_to_idle", {62'h0, out_valid, in_ready}, 64'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'hFFFF_FFFF_FFFF_FFFF; in_sub = 1'b0;
    check_output("second_accepted", {63'h0, in_ready}, 64'h0);
    repeat (4) @(posedge clk);
    #1;
    check_output("second_result", out_result, 64'h0000_0000_0000_000D);
    check_output("second_flags", {60'h0, out_valid, out_cout, out_ovf, out_zero}, 64'hC);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    in_valid = 1'b1; in_sub = 1'b0; in_a = 64'h1111_2222_3333_4444; in_b = 64'h0000_0000_0000_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("mid_run_add_a", {48'h0, add_a}, 64'h2222);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_adder", {31'h0, add_a, add_b, add_cin}, 64'h0);
    check_output("async_rst_result", out_result, 64'h0);
    check_output("async_rst_ctrl", {59'h0, out_valid, in_ready, out_cout, out_ovf, out_zero}, 64'h8);
    @(negedge clk);
    rst_n = 1'b1;
    late_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      late_valid[c] = out_valid;
    end
    check_output("no_valid_after_rst", {59'h0, late_valid, in_ready}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
